// File: rtl/ui_debounce_pkg.sv
// rtl/ui_debounce_pkg.sv - shared constants, per-bit state type and saturation helper
package ui_debounce_pkg;

  localparam int DEF_WIDTH           = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 8;

  // Stability counter field wide enough for the largest legal threshold (255)
  localparam int DB_CNT_W = $clog2(255);

  typedef struct packed {
    logic [DB_CNT_W-1:0] cnt;
    logic                clean;
  } db_state_t;

  function automatic int unsigned cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchroniser, debouncer and edge-pulse generator
module debounce_bit
  import ui_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic change
);

  localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  db_state_t              state_q;
  db_state_t              state_d;
  logic                   flip;

  // Synchroniser runs regardless of ena so the pad is always tracked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    flip    = 1'b0;
    if (ena) begin
      if (sync_q == state_q.clean) begin
        state_d.cnt = '0;
      end else if (state_q.cnt == DB_LIMIT) begin
        state_d.clean = sync_q;
        state_d.cnt   = '0;
        flip          = 1'b1;
      end else begin
        state_d.cnt = state_q.cnt + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      rise    <= flip & sync_q;
      fall    <= flip & ~sync_q;
    end
  end

  assign clean  = state_q.clean;
  assign change = flip;

endmodule

// File: rtl/ui_debounce_sync.sv
// rtl/ui_debounce_sync.sv - per-bit debounce array plus saturating clean-change counter
module ui_debounce_sync
  import ui_debounce_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [CNT_W-1:0] change_cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(CNT_W));

  logic [WIDTH-1:0] bit_change;
  logic             any_change;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .raw   (raw_in[i]),
      .clean (clean_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i]),
      .change(bit_change[i])
    );
  end

  // Several bits flipping together still count as one event cycle
  assign any_change = |bit_change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_cnt <= '0;
    end else if (any_change && (change_cnt != CNT_SAT)) begin
      change_cnt <= change_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ui_debounce_sync.sv
// tb/tb_ui_debounce_sync.sv - directed self-checking bench for ui_debounce_sync
module tb_ui_debounce_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [7:0] change_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  ui_debounce_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving the bench on the following falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  logic [1:0] pulse_seen;
  logic [1:0] clean_seen;
  int         exp_cnt;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_clean", clean_out, 2'b00);
    check("rst_rise", rise_pulse, 2'b00);
    check("rst_fall", fall_pulse, 2'b00);
    check("rst_cnt", change_cnt, 8'd0);

    // 1. Latency from reset release
    rst_n = 1'b1;
    clean_seen = 2'b00;
    pulse_seen = 2'b00;
    for (int k = 1; k <= 17; k++) begin
      step(1);
      clean_seen = clean_seen | clean_out;
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
    check("lat_clean_pre", clean_seen, 2'b00);
    check("lat_pulse_pre", pulse_seen, 2'b00);
    check("lat_cnt_pre", change_cnt, 8'd0);
    step(1);
    check("lat_clean_18", clean_out, 2'b11);
    check("lat_rise_18", rise_pulse, 2'b11);
    check("lat_fall_18", fall_pulse, 2'b00);
    check("lat_cnt_18", change_cnt, 8'd1);
    step(1);
    check("lat_rise_19", rise_pulse, 2'b00);
    check("lat_clean_19", clean_out, 2'b11);

    // 2. Glitch reject on bit 0
    raw_in = 2'b10;
    step(20);
    check("g_setup_clean", clean_out, 2'b10);
    check("g_setup_cnt", change_cnt, 8'd2);
    raw_in = 2'b11;
    pulse_seen = 2'b00;
    for (int k = 0; k < 35; k++) begin
      if (k == 15) raw_in = 2'b10;
      step(1);
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
    check("g_clean", clean_out, 2'b10);
    check("g_pulse", pulse_seen, 2'b00);
    check("g_cnt", change_cnt, 8'd2);

    // 3. Exact threshold on bit 1
    raw_in = 2'b00;
    pulse_seen = 2'b00;
    for (int k = 0; k < 17; k++) begin
      step(1);
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
    check("thr_pulse_pre", pulse_seen, 2'b00);
    check("thr_clean_pre", clean_out, 2'b10);
    step(1);
    check("thr_fall", fall_pulse, 2'b10);
    check("thr_rise", rise_pulse, 2'b00);
    check("thr_clean", clean_out, 2'b00);
    check("thr_cnt", change_cnt, 8'd3);
    step(1);
    check("thr_fall_off", fall_pulse, 2'b00);
    raw_in = 2'b10;
    pulse_seen = 2'b00;
    for (int k = 0; k < 35; k++) begin
      if (k == 15) raw_in = 2'b00;
      step(1);
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
    check("thr15_clean", clean_out, 2'b00);
    check("thr15_pulse", pulse_seen, 2'b00);
    check("thr15_cnt", change_cnt, 8'd3);

    // 4. ena freeze at counter value 8
    raw_in = 2'b01;
    step(10);
    ena = 1'b0;
    pulse_seen = 2'b00;
    for (int k = 0; k < 50; k++) begin
      step(1);
      pulse_seen = pulse_seen | rise_pulse | fall_pulse;
    end
    check("frz_clean", clean_out, 2'b00);
    check("frz_pulse", pulse_seen, 2'b00);
    check("frz_cnt", change_cnt, 8'd3);
    ena = 1'b1;
    step(7);
    check("frz_clean_7", clean_out, 2'b00);
    step(1);
    check("frz_clean_8", clean_out, 2'b01);
    check("frz_rise_8", rise_pulse, 2'b01);
    check("frz_cnt_8", change_cnt, 8'd4);

    // 5. Saturation of change_cnt
    exp_cnt = 4;
    for (int i = 0; i < 300; i++) begin
      raw_in[0] = ~raw_in[0];
      step(40);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check("sat_clean", clean_out, raw_in);
      check("sat_cnt", change_cnt, exp_cnt);
    end
    check("sat_final", change_cnt, 8'd255);

    // 6. Async reset mid-debounce (bit 1 at counter 10)
    raw_in = 2'b11;
    step(12);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_clean", clean_out, 2'b00);
    check("ar_cnt", change_cnt, 8'd0);
    check("ar_pulse", rise_pulse | fall_pulse, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    clean_seen = 2'b00;
    for (int k = 0; k < 17; k++) begin
      step(1);
      clean_seen = clean_seen | clean_out;
    end
    check("ar_clean_pre", clean_seen, 2'b00);
    step(1);
    check("ar_clean_18", clean_out, 2'b11);
    check("ar_rise_18", rise_pulse, 2'b11);
    check("ar_cnt_18", change_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
